// File: rtl/cpu7_csr_ctl.sv
// cpu7_csr_ctl: execute-stage CSR read/modify/write sequencer with ERTN and exception redirect
module cpu7_csr_ctl #(
  parameter int GRLEN   = 32,
  parameter int CSR_BIT = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ecl_csr_req,
  input  logic [1:0]         ecl_csr_op,
  input  logic [CSR_BIT-1:0] ecl_csr_num,
  input  logic [GRLEN-1:0]   ecl_csr_rd_val,
  input  logic [GRLEN-1:0]   ecl_csr_rj_val,
  input  logic               ecl_csr_ale_e,
  output logic               csr_ready,
  output logic               csr_done,
  output logic [GRLEN-1:0]   csr_result,
  output logic [CSR_BIT-1:0] csr_raddr,
  input  logic [GRLEN-1:0]   csr_rdata,
  output logic [CSR_BIT-1:0] csr_waddr,
  output logic [GRLEN-1:0]   csr_wdata,
  output logic               csr_wen,
  input  logic [GRLEN-1:0]   csr_era,
  input  logic [GRLEN-1:0]   csr_eentry,
  output logic               redirect_valid,
  output logic [GRLEN-1:0]   redirect_pc
);
  localparam logic [1:0] IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, DONE = 2'd3;
  localparam logic [1:0] OP_RD = 2'd0, OP_XCHG = 2'd2, OP_ERTN = 2'd3;
  localparam logic [CSR_BIT-1:0] CRMD = '0, PRMD = CSR_BIT'(1);
  logic [1:0]         state, op_q;
  logic [CSR_BIT-1:0] num_q;
  logic [GRLEN-1:0]   rd_q, rj_q, old_q;
  logic               ertn;
  assign ertn      = op_q == OP_ERTN;
  assign csr_ready = state == IDLE;
  assign csr_raddr = (state == READ && ertn) ? PRMD : num_q;
  assign csr_waddr = (state == WRITE && ertn) ? CRMD : num_q;
  assign csr_wen   = state == WRITE && !ecl_csr_ale_e;
  // ERTN restores IE from PIE and PLV from PPLV, which share bit positions in PRMD/CRMD
  assign csr_wdata = op_q == OP_XCHG ? (old_q & ~rj_q) | (rd_q & rj_q)
                   : ertn            ? {{(GRLEN-3){1'b0}}, old_q[2], old_q[1:0]}
                   : rd_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      op_q           <= '0;
      num_q          <= '0;
      rd_q           <= '0;
      rj_q           <= '0;
      old_q          <= '0;
      csr_done       <= 1'b0;
      csr_result     <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      csr_done       <= 1'b0;
      redirect_valid <= ecl_csr_ale_e || (state == WRITE && ertn);
      if (ecl_csr_ale_e) begin
        state       <= IDLE;
        redirect_pc <= csr_eentry;
      end else begin
        case (state)
          IDLE: if (ecl_csr_req) begin
            op_q  <= ecl_csr_op;
            num_q <= ecl_csr_num;
            rd_q  <= ecl_csr_rd_val;
            rj_q  <= ecl_csr_rj_val;
            state <= READ;
          end
          READ: begin
            old_q <= csr_rdata;
            state <= op_q == OP_RD ? DONE : WRITE;
            if (op_q == OP_RD) begin
              csr_done   <= 1'b1;
              csr_result <= csr_rdata;
            end
          end
          WRITE: begin
            state      <= DONE;
            csr_done   <= 1'b1;
            csr_result <= ertn ? '0 : old_q;
            if (ertn) redirect_pc <= csr_era;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_cpu7_csr_ctl.sv
// tb_cpu7_csr_ctl: directed checks of the CSR sequencer against a small CSR file model
module tb_cpu7_csr_ctl;
  logic        clk = 1'b0, reset;
  logic        req, ale;
  logic [1:0]  op;
  logic [13:0] num;
  logic [31:0] rd, rj;
  logic        ready, done, wen, rv;
  logic [31:0] result, rdata, wdata, era, eentry, rpc;
  logic [13:0] raddr, waddr;
  logic        pre_en;
  logic [3:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] mem [16] = '{default: 32'h0};
  int checks = 0, errors = 0;

  cpu7_csr_ctl dut (
    .clk(clk), .reset(reset), .ecl_csr_req(req), .ecl_csr_op(op), .ecl_csr_num(num),
    .ecl_csr_rd_val(rd), .ecl_csr_rj_val(rj), .ecl_csr_ale_e(ale), .csr_ready(ready),
    .csr_done(done), .csr_result(result), .csr_raddr(raddr), .csr_rdata(rdata),
    .csr_waddr(waddr), .csr_wdata(wdata), .csr_wen(wen), .csr_era(era),
    .csr_eentry(eentry), .redirect_valid(rv), .redirect_pc(rpc)
  );

  always #5 clk = ~clk;
  assign rdata  = mem[raddr[3:0]];
  assign era    = mem[6];
  assign eentry = mem[12];
  always @(posedge clk) begin
    if (wen) mem[waddr[3:0]] <= wdata;
    if (pre_en) mem[pre_addr] <= pre_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [3:0] a, input logic [31:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_en = 1'b0;
  endtask

  task automatic start(input logic [1:0] o, input logic [13:0] n, input logic [31:0] d, input logic [31:0] m);
    req = 1'b1; op = o; num = n; rd = d; rj = m;
    tick();
    req = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_result"}, result, 32'h0);
    chk({tag, "_wen"}, 32'(wen), 32'd0);
    chk({tag, "_rv"}, 32'(rv), 32'd0);
    chk({tag, "_rpc"}, rpc, 32'h0);
    chk({tag, "_raddr"}, 32'(raddr), 32'h0);
    chk({tag, "_waddr"}, 32'(waddr), 32'h0);
    chk({tag, "_wdata"}, wdata, 32'h0);
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; ale = 1'b0; op = 2'd0; num = 14'd0; rd = 32'h0; rj = 32'h0;
    pre_en = 1'b0; pre_addr = 4'd0; pre_data = 32'h0;
    #3;
    chk_reset_vals("rst");
    tick(); tick();
    reset = 1'b0;
    preload(4'hc, 32'h1c000100);

    start(2'd0, 14'hc, 32'h0, 32'h0);
    chk("rd_raddr", 32'(raddr), 32'hc);
    chk("rd_ready_busy", 32'(ready), 32'd0);
    chk("rd_wen_t1", 32'(wen), 32'd0);
    tick();
    chk("rd_done", 32'(done), 32'd1);
    chk("rd_result", result, 32'h1c000100);
    chk("rd_wen_t2", 32'(wen), 32'd0);
    tick();
    chk("rd_done_pulse", 32'(done), 32'd0);
    chk("rd_ready_back", 32'(ready), 32'd1);

    start(2'd1, 14'h6, 32'h80001234, 32'h0);
    chk("wr_raddr", 32'(raddr), 32'h6);
    chk("wr_wen_t1", 32'(wen), 32'd0);
    tick();
    chk("wr_wen", 32'(wen), 32'd1);
    chk("wr_waddr", 32'(waddr), 32'h6);
    chk("wr_wdata", wdata, 32'h80001234);
    chk("wr_done_t2", 32'(done), 32'd0);
    tick();
    chk("wr_done", 32'(done), 32'd1);
    chk("wr_result", result, 32'h0);
    chk("wr_rv", 32'(rv), 32'd0);
    tick();
    start(2'd0, 14'h6, 32'h0, 32'h0);
    tick();
    chk("wr_readback", result, 32'h80001234);
    tick();

    start(2'd2, 14'h0, 32'h7, 32'h4);
    tick();
    chk("xchg_wen", 32'(wen), 32'd1);
    chk("xchg_waddr", 32'(waddr), 32'h0);
    chk("xchg_wdata", wdata, 32'h4);
    tick();
    chk("xchg_done", 32'(done), 32'd1);
    chk("xchg_result", result, 32'h0);
    tick();
    chk("xchg_mem", mem[0], 32'h4);

    preload(4'h6, 32'h1c000200);
    preload(4'h1, 32'h7);
    start(2'd3, 14'h3, 32'h0, 32'h0);
    chk("ertn_raddr", 32'(raddr), 32'h1);
    tick();
    chk("ertn_wen", 32'(wen), 32'd1);
    chk("ertn_waddr", 32'(waddr), 32'h0);
    chk("ertn_wdata", wdata, 32'h7);
    chk("ertn_rv_t2", 32'(rv), 32'd0);
    tick();
    chk("ertn_done", 32'(done), 32'd1);
    chk("ertn_result", result, 32'h0);
    chk("ertn_rv", 32'(rv), 32'd1);
    chk("ertn_rpc", rpc, 32'h1c000200);
    tick();
    chk("ertn_rv_pulse", 32'(rv), 32'd0);
    chk("ertn_result_hold", result, 32'h0);

    preload(4'hc, 32'h1c008000);
    start(2'd1, 14'h6, 32'hdeadbeef, 32'h0);
    tick();
    ale = 1'b1;
    #1;
    chk("exc_wen_forced", 32'(wen), 32'd0);
    tick();
    ale = 1'b0;
    chk("exc_no_done", 32'(done), 32'd0);
    chk("exc_rv", 32'(rv), 32'd1);
    chk("exc_rpc", rpc, 32'h1c008000);
    chk("exc_ready", 32'(ready), 32'd1);
    tick();
    chk("exc_no_late_done", 32'(done), 32'd0);
    chk("exc_rv_pulse", 32'(rv), 32'd0);
    chk("exc_era_kept", mem[6], 32'h1c000200);

    req = 1'b1; op = 2'd0; num = 14'hc; ale = 1'b1;
    tick();
    req = 1'b0; ale = 1'b0;
    chk("exc_req_ignored", 32'(ready), 32'd1);
    chk("exc_req_rv", 32'(rv), 32'd1);
    tick();
    chk("exc_req_no_done", 32'(done), 32'd0);

    start(2'd1, 14'h6, 32'h12345678, 32'h0);
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    tick();
    reset = 1'b0;
    chk("midrst_era_kept", mem[6], 32'h1c000200);
    start(2'd0, 14'hc, 32'h0, 32'h0);
    chk("post_rst_busy", 32'(ready), 32'd0);
    tick();
    chk("post_rst_done", 32'(done), 32'd1);
    chk("post_rst_result", result, 32'h1c008000);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
